// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR filter: NTAPS programmable coefficients, sample history,
// and one shared DW x DW multiplier stepped across the taps one per cycle.
// Each accepted sample yields one saturated output with a one-cycle y_valid pulse.
module fir_tap_sequencer #(
    parameter int NTAPS = 4,
    parameter int DW    = 8,
    parameter int ACCW  = 20,
    parameter int SHIFT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          coef_wr,
    input  logic [3:0]    coef_addr,
    input  logic [DW-1:0] coef_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x_in,
    input  logic          flush,
    output logic [DW-1:0] y_out,
    output logic          y_valid,
    output logic          busy
);

    localparam int TW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   h [NTAPS];
    logic [DW-1:0]   x [NTAPS];
    logic [ACCW-1:0] acc;
    logic [TW-1:0]   tap;
    logic [2*DW-1:0] prod;
    logic            addr_ok;
    logic            accept;
    logic            do_wr;
    logic            do_flush;

    // Scale the accumulator down and clamp it to the DW-bit output range.
    function automatic logic [DW-1:0] saturate(input logic [ACCW-1:0] a);
        logic [ACCW-1:0] t;
        t = a >> SHIFT;
        if (t > {{(ACCW-DW){1'b0}}, {DW{1'b1}}})
            return {DW{1'b1}};
        else
            return t[DW-1:0];
    endfunction

    assign addr_ok = (32'(coef_addr) < 32'(NTAPS));
    assign prod    = {{DW{1'b0}}, h[tap]} * {{DW{1'b0}}, x[tap]};

    // State register; reset during a MAC run simply abandons the sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and handshake decode; coef_wr outranks flush, which outranks a sample.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        do_wr     = 1'b0;
        do_flush  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~coef_wr & ~flush;
                do_wr    = coef_wr & addr_ok;
                do_flush = ~coef_wr & flush;
                accept   = in_valid & ~coef_wr & ~flush;
                if (accept)
                    state_nxt = MAC;
            end
            MAC: begin
                busy = 1'b1;
                if (tap == TW'(NTAPS - 1))
                    state_nxt = OUT;
            end
            OUT: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Coefficient table, history shift, multiply-accumulate and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                h[k] <= '0;
                x[k] <= '0;
            end
            acc     <= '0;
            tap     <= '0;
            y_out   <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            if (do_wr)
                h[coef_addr[TW-1:0]] <= coef_data;
            if (do_flush) begin
                for (int k = 0; k < NTAPS; k++)
                    x[k] <= '0;
            end
            if (accept) begin
                x[0] <= x_in;
                for (int k = 1; k < NTAPS; k++)
                    x[k] <= x[k-1];
                acc <= '0;
                tap <= '0;
            end
            if (state == MAC) begin
                acc <= acc + {{(ACCW-2*DW){1'b0}}, prod};
                tap <= tap + TW'(1);
            end
            if (state == OUT) begin
                y_out   <= saturate(acc);
                y_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: two instances (SHIFT=0 and SHIFT=2) share
// stimulus; a convolution model pushes expected outputs and arrival cycles to queues.
module tb_fir_tap_sequencer;

    localparam int NT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coef_wr = 1'b0;
    logic [3:0] coef_addr = '0;
    logic [7:0] coef_data = '0;
    logic       in_valid = 1'b0;
    logic [7:0] x_in = '0;
    logic       flush = 1'b0;

    logic       in_ready0, y_valid0, busy0;
    logic [7:0] y0;
    logic       in_ready2, y_valid2, busy2;
    logic [7:0] y2;

    typedef struct {int v; int c;} exp_t;
    exp_t q0[$];
    exp_t q2[$];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int mh[NT];
    int mx[NT];
    int last0 = 0;
    bit ev0, ev2;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fir_tap_sequencer #(.NTAPS(NT), .DW(8), .ACCW(20), .SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .coef_wr(coef_wr), .coef_addr(coef_addr),
        .coef_data(coef_data), .in_valid(in_valid), .in_ready(in_ready0),
        .x_in(x_in), .flush(flush), .y_out(y0), .y_valid(y_valid0), .busy(busy0)
    );

    fir_tap_sequencer #(.NTAPS(NT), .DW(8), .ACCW(20), .SHIFT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .coef_wr(coef_wr), .coef_addr(coef_addr),
        .coef_data(coef_data), .in_valid(in_valid), .in_ready(in_ready2),
        .x_in(x_in), .flush(flush), .y_out(y2), .y_valid(y_valid2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat8(input int s);
        return (s > 255) ? 255 : s;
    endfunction

    // Model: shift history, convolve, queue expected values due at cycle c.
    task automatic push_sample(input int v, input int c);
        int sum;
        for (int k = NT - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = v;
        sum = 0;
        for (int k = 0; k < NT; k++) sum += mh[k] * mx[k];
        q0.push_back('{sat8(sum), c});
        q2.push_back('{sat8(sum >> 2), c});
        last0 = sat8(sum);
    endtask

    // Output monitor: y_valid must pulse exactly on the cycle the model predicts.
    always @(negedge clk) begin
        if (rst_n) begin
            ev0 = (q0.size() > 0) && (q0[0].c == cyc);
            ev2 = (q2.size() > 0) && (q2[0].c == cyc);
            chk("y_valid_s0", 32'(y_valid0), 32'(ev0));
            chk("y_valid_s2", 32'(y_valid2), 32'(ev2));
            if (ev0) begin
                chk("y_out_s0", 32'(y0), 32'(q0[0].v));
                void'(q0.pop_front());
            end
            if (ev2) begin
                chk("y_out_s2", 32'(y2), 32'(q2[0].v));
                void'(q2.pop_front());
            end
        end
    end

    // Present a sample (in_valid left high) and wait, bounded, for it to be taken.
    task automatic send(input int v);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        x_in = 8'(v);
        #1;
        while (!in_ready0 && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 40) begin
            chk("accept_timeout", 32'(in_ready0), 32'd1);
        end else begin
            push_sample(v, cyc + NT + 2);
            @(posedge clk);
            #1;
            chk("in_ready_mac", 32'(in_ready0), 32'd0);
            chk("busy_mac", 32'(busy0), 32'd1);
        end
    endtask

    task automatic wr_coef(input int addr, input int data, input bit applies,
                           input bit with_sample, input int sv);
        @(negedge clk);
        #1;
        coef_wr = 1'b1;
        coef_addr = 4'(addr);
        coef_data = 8'(data);
        if (with_sample) begin
            in_valid = 1'b1;
            x_in = 8'(sv);
        end
        #1;
        chk("in_ready_wr", 32'(in_ready0), 32'd0);
        @(posedge clk);
        #1;
        coef_wr = 1'b0;
        if (applies) mh[addr] = data;
        chk("y_hold_wr", 32'(y0), 32'(last0));
    endtask

    task automatic do_flush();
        @(negedge clk);
        #1;
        flush = 1'b1;
        #1;
        chk("in_ready_flush", 32'(in_ready0), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        for (int k = 0; k < NT; k++) mx[k] = 0;
        chk("y_hold_flush", 32'(y0), 32'(last0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NT; k++) begin
            mh[k] = 0;
            mx[k] = 0;
        end
        // Power-on reset state
        repeat (2) @(negedge clk);
        chk("rst_y_out", 32'(y0), 32'd0);
        chk("rst_y_valid", 32'(y_valid0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready0), 32'd1);

        // h = {1,2,3,4}; continuous in_valid: 10,20,30,40,50
        wr_coef(0, 1, 1'b1, 1'b0, 0);
        wr_coef(1, 2, 1'b1, 1'b0, 0);
        wr_coef(2, 3, 1'b1, 1'b0, 0);
        wr_coef(3, 4, 1'b1, 1'b0, 0);
        send(10);
        send(20);
        send(30);
        send(40);
        send(50);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);

        // Coefficient write during MAC is ignored
        send(60);
        in_valid = 1'b0;
        wr_coef(2, 9, 1'b0, 1'b0, 0);
        repeat (8) @(negedge clk);

        // Out-of-range address is ignored (must not alias onto h[3])
        wr_coef(7, 0, 1'b0, 1'b0, 0);
        // Coefficient write together with a sample: write first, sample next cycle
        wr_coef(0, 2, 1'b1, 1'b1, 1);
        send(1);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);

        // Flush history, then a lone sample through h = {1,2,3,4}
        wr_coef(0, 1, 1'b1, 1'b0, 0);
        do_flush();
        send(5);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);

        // Reset in the middle of a MAC run: no output for the aborted sample
        send(7);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q0.delete();
        q2.delete();
        last0 = 0;
        for (int k = 0; k < NT; k++) begin
            mh[k] = 0;
            mx[k] = 0;
        end
        #1;
        chk("abort_y_out", 32'(y0), 32'd0);
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_y_valid", 32'(y_valid0), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready", 32'(in_ready0), 32'd1);
        repeat (10) @(negedge clk);
        // Coefficients cleared: any input gives 0
        send(100);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
